// File: rtl/verifier_chi_arbiter.sv
// Round-robin arbiter and sequencer sharing one chi/dot-product unit between
// nReq requesters: latches the winner's operands, pulses chi_en, follows the
// unit's ready low/high handshake and returns the dot product with a done strobe.
module verifier_chi_arbiter #(
    parameter int nReq     = 2,
    parameter int nValBits = 3,
    parameter int F_NBITS  = 61,
    localparam int nValues = 1 << nValBits
) (
    input  logic                                      clk,
    input  logic                                      rstb,
    input  logic [nReq-1:0]                           req,
    input  logic [nReq-1:0][nValBits-1:0][F_NBITS-1:0] tau_req,
    input  logic [nReq-1:0][nValues-1:0][F_NBITS-1:0]  vals_req,
    output logic [nReq-1:0]                           grant,
    output logic [nReq-1:0]                           done,
    output logic [F_NBITS-1:0]                        dotp_out,
    output logic                                      busy,
    output logic                                      chi_en,
    output logic [nValBits-1:0][F_NBITS-1:0]          chi_tau,
    output logic [nValues-1:0][F_NBITS-1:0]           chi_vals,
    input  logic                                      chi_ready,
    input  logic [F_NBITS-1:0]                        chi_dotp
);

    localparam int PW = $clog2(nReq);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t state, state_next;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    // Winner search: first set request strictly after ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= nReq; i++) begin
            idx = int'(ptr) + i;
            if (idx >= nReq) begin
                idx = idx - nReq;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded strobes.
    always_comb begin
        state_next = state;
        chi_en     = 1'b0;
        busy       = 1'b1;
        done       = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (found) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                chi_en     = 1'b1;
                state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!chi_ready) begin
                    state_next = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (chi_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = grant;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant, pointer, operand snapshot and result registers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            grant    <= '0;
            ptr      <= PW'(nReq - 1);
            chi_tau  <= '0;
            chi_vals <= '0;
            dotp_out <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant      <= '0;
                grant[win] <= 1'b1;
                ptr        <= win;
                chi_tau    <= tau_req[win];
                chi_vals   <= vals_req[win];
            end
            if (state == WAIT_HIGH && chi_ready) begin
                dotp_out <= chi_dotp;
            end
            if (state == DONE) begin
                grant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_verifier_chi_arbiter.sv
// Scoreboard bench for verifier_chi_arbiter with a behavioural chi unit mock.
module tb_verifier_chi_arbiter;

    localparam int NR  = 4;
    localparam int NVB = 3;
    localparam int NV  = 1 << NVB;
    localparam int FN  = 61;

    logic                            clk;
    logic                            rstb;
    logic [NR-1:0]                   req;
    logic [NR-1:0][NVB-1:0][FN-1:0]  tau_drv;
    logic [NR-1:0][NV-1:0][FN-1:0]   vals_drv;
    logic [NR-1:0]                   grant;
    logic [NR-1:0]                   done;
    logic [FN-1:0]                   dotp_out;
    logic                            busy;
    logic                            chi_en;
    logic [NVB-1:0][FN-1:0]          chi_tau;
    logic [NV-1:0][FN-1:0]           chi_vals;
    logic                            chi_ready;
    logic [FN-1:0]                   chi_dotp;

    logic [NR-1:0][NVB-1:0][FN-1:0]  tau_tab;
    logic [NR-1:0][NV-1:0][FN-1:0]   vals_tab;
    logic [FN-1:0]                   dot_tab [NR];

    typedef struct {
        logic [NR-1:0] d;
        logic [FN-1:0] v;
    } exp_t;
    exp_t sb [$];

    int checks = 0;
    int errors = 0;
    int en_count = 0;
    int exp_en = 0;
    int lat = 6;

    logic [NR-1:0] want;
    int            blk_cnt [NR];
    logic [NR-1:0] blk;

    verifier_chi_arbiter #(
        .nReq(NR),
        .nValBits(NVB),
        .F_NBITS(FN)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .req(req),
        .tau_req(tau_drv),
        .vals_req(vals_drv),
        .grant(grant),
        .done(done),
        .dotp_out(dotp_out),
        .busy(busy),
        .chi_en(chi_en),
        .chi_tau(chi_tau),
        .chi_vals(chi_vals),
        .chi_ready(chi_ready),
        .chi_dotp(chi_dotp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Chi unit mock: ready drops after chi_en, rises lat cycles later with a result
    // derived from the operands presented at that moment.
    int mock_cnt;
    always @(posedge clk) begin
        if (!rstb) begin
            chi_ready <= 1'b1;
            chi_dotp  <= '0;
            mock_cnt  <= 0;
        end else if (chi_en) begin
            chi_ready <= 1'b0;
            mock_cnt  <= lat;
        end else if (mock_cnt > 0) begin
            mock_cnt <= mock_cnt - 1;
            if (mock_cnt == 1) begin
                chi_ready <= 1'b1;
                chi_dotp  <= chi_tau[0] + chi_vals[NV-1];
            end
        end
    end

    // Requester agent: each requester withholds its request for the cycle after done.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (done[i]) blk_cnt[i] <= 2;
            else if (blk_cnt[i] > 0) blk_cnt[i] <= blk_cnt[i] - 1;
        end
    end

    always_comb begin
        blk = '0;
        for (int i = 0; i < NR; i++) blk[i] = (blk_cnt[i] != 0);
        req = want & ~blk;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse, checks operand stability while granted.
    always @(negedge clk) begin
        if (rstb) begin
            if (chi_en) en_count++;
            if (done != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got %0h expected none", done);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_vec", done, e.d);
                    chk("dotp_out", dotp_out, e.v);
                end
            end
            if (grant != '0) begin
                int g;
                g = 0;
                for (int i = 0; i < NR; i++) if (grant[i]) g = i;
                chk("grant_onehot", $onehot(grant), 1);
                chk("busy_granted", busy, 1);
                chk("chi_tau", chi_tau, tau_tab[g]);
                chk("chi_vals", chi_vals, vals_tab[g]);
            end
        end
    end

    task automatic push(input int i);
        logic [NR-1:0] one;
        exp_t e;
        one = 1;
        e.d = one << i;
        e.v = dot_tab[i];
        sb.push_back(e);
        exp_en++;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        want = '0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got 0 expected 1");
        end
    endtask

    initial begin
        logic [63:0] r;
        int n;

        dot_tab[0] = 61'h1234;
        dot_tab[1] = 61'h2567;
        dot_tab[2] = 61'h389A;
        dot_tab[3] = 61'h4BCD;
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < NVB; k++) tau_tab[i][k] = FN'(32'h100 * (i + 1) + k + 32'h50);
            for (int k = 0; k < NV; k++) vals_tab[i][k] = FN'(32'h10000 * (i + 1) + 32'h33 * k);
        end
        tau_tab[0][0] = 61'h1000; vals_tab[0][NV-1] = 61'h0234;
        tau_tab[1][0] = 61'h2000; vals_tab[1][NV-1] = 61'h0567;
        tau_tab[2][0] = 61'h3000; vals_tab[2][NV-1] = 61'h089A;
        tau_tab[3][0] = 61'h4000; vals_tab[3][NV-1] = 61'h0BCD;
        tau_drv  = tau_tab;
        vals_drv = vals_tab;
        for (int i = 0; i < NR; i++) blk_cnt[i] = 0;

        // Reset state
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_chi_en", chi_en, 0);
        chk("rst_dotp", dotp_out, 0);
        chk("rst_chi_tau", chi_tau, 0);
        chk("rst_chi_vals", chi_vals, 0);

        // Single request
        lat  = 6;
        want = 4'b0001;
        push(0);
        @(negedge clk);
        chk("single_grant_c1", grant, 4'b0001);
        chk("single_chi_en_c1", chi_en, 1);
        chk("single_busy_c1", busy, 1);
        @(negedge clk);
        chk("single_chi_en_c2", chi_en, 0);
        wait_drain(40);
        want = '0;
        repeat (3) @(negedge clk);
        chk("single_busy_after", busy, 0);
        chk("single_grant_after", grant, 0);
        chk("single_dotp_held", dotp_out, 61'h1234);

        // Simultaneous requests after reset
        do_reset();
        want = 4'b0011;
        push(0);
        push(1);
        wait_drain(60);
        want = '0;
        repeat (3) @(negedge clk);

        // Fairness with all four requesting
        do_reset();
        lat  = 1;
        want = 4'b1111;
        for (int rep = 0; rep < 3; rep++)
            for (int i = 0; i < NR; i++) push(i);
        wait_drain(400);
        want = '0;
        repeat (3) @(negedge clk);

        // Operand stability: requester 0 scrambles its inputs after the grant
        lat  = 6;
        want = 4'b0001;
        push(0);
        wait_busy(20);
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            for (int k = 0; k < NVB; k++) begin
                r = {$urandom(), $urandom()};
                tau_drv[0][k] = r[FN-1:0];
            end
            for (int k = 0; k < NV; k++) begin
                r = {$urandom(), $urandom()};
                vals_drv[0][k] = r[FN-1:0];
            end
            @(negedge clk);
            n++;
        end
        want = '0;
        wait_drain(5);
        tau_drv  = tau_tab;
        vals_drv = vals_tab;
        repeat (3) @(negedge clk);

        // Reset while waiting for ready high
        want = 4'b0100;
        exp_en++;
        wait_busy(20);
        want = '0;
        repeat (4) @(negedge clk);
        chk("mid_in_wait_high", {busy, chi_ready}, 2'b10);
        rstb = 1'b0;
        @(negedge clk);
        chk("midrst_grant", grant, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_chi_en", chi_en, 0);
        chk("midrst_dotp", dotp_out, 0);
        chk("midrst_chi_tau", chi_tau, 0);
        chk("midrst_chi_vals", chi_vals, 0);
        rstb = 1'b1;
        want = 4'b1010;
        push(1);
        push(3);
        wait_drain(60);
        want = '0;
        repeat (4) @(negedge clk);

        chk("final_busy", busy, 0);
        chk("final_grant", grant, 0);
        chk("chi_en_count", en_count, exp_en);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
